clm_mul_sched: RTL and testbench

- Shares one masked CLM multiplier instance between N_REQ requesters, using round-robin arbitration.
- For each operation it:
  - captures the winning requester's operands and p_det;
  - collects fresh randomness from a byte-wide RNG stream;
  - issues a one-cycle drdy_i to the multiplier and waits for drdy_o;
  - routes the product back to the winner.
- Sits between the key-schedule/S-box issue logic and the multiplier plus p_param_extractor pair.

---
 rtl/clm_sched_pkg.sv | 13 +
 rtl/clm_mul_sched_rr_arb.sv | 28 ++
 rtl/clm_mul_sched.sv | 129 ++++++++++++
 tb/tb_clm_mul_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clm_sched_pkg.sv
// clm_sched_pkg: shared state encoding, p_det types and randomness sizing for the CLM multiplier scheduler.
package clm_sched_pkg;
    typedef enum logic [2:0] {IDLE, RND, ISSUE, WAIT, RESP} sched_state_t;
    typedef logic [4:0] p_det_t;
    typedef logic [4:0] red_poly_t;

    function automatic int rnd_bytes(input int d);
        return 9 + d;
    endfunction

    localparam int D_DEF = 1;
    localparam int RND_BYTES = rnd_bytes(D_DEF);
endpackage

// File: rtl/clm_mul_sched_rr_arb.sv
// clm_rr_arb: combinational round-robin select, first requester at or after ptr (wrapping).
module clm_rr_arb #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic          found;
    logic [IW-1:0] k;

    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        k = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr) + i) % N);
            if (!found && req[k]) begin
                found = 1'b1;
                grant[k] = 1'b1;
                idx = k;
            end
        end
    end
endmodule

// File: rtl/clm_mul_sched.sv
// clm_mul_sched: round-robin sharing of one masked CLM multiplier, with per-operation fresh randomness.
// Optional WAIT watchdog enabled by defining CLM_MUL_TMO_EN.
module clm_mul_sched
    import clm_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int D       = 1,
    parameter int P_W     = 16,
    parameter int TMO_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*P_W-1:0]      req_p1,
    input  logic [N_REQ*P_W-1:0]      req_p2,
    input  logic [N_REQ*5-1:0]        req_pdet,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [P_W-1:0]            resp_data,
    output logic                      resp_err,
    input  logic                      rnd_valid,
    input  logic [7:0]                rnd_data,
    output logic                      rnd_ready,
    output logic                      mul_drdy_i,
    output logic [P_W-1:0]            mul_p1,
    output logic [P_W-1:0]            mul_p2,
    output logic [8*rnd_bytes(D)-1:0] mul_random_vect,
    output logic [4:0]                mul_p_det,
    input  logic                      mul_drdy_o,
    input  logic [P_W-1:0]            mul_out
);
    localparam int RB = rnd_bytes(D);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(RB);

    sched_state_t      state, state_nx;
    logic [IW-1:0]     ptr, gidx, g;
    logic [N_REQ-1:0]  gnt;
    logic [CW-1:0]     cnt;
    logic [P_W-1:0]    p1_q, p2_q;
    p_det_t            pdet_q;
    logic [8*RB-1:0]   rv_q;
    logic              tmo;

    clm_rr_arb #(.N(N_REQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gidx)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req_valid ? RND : IDLE;
            RND:     state_nx = (rnd_valid && cnt == CW'(RB - 1)) ? ISSUE : RND;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (mul_drdy_o || tmo) ? RESP : WAIT;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            g         <= '0;
            cnt       <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            pdet_q    <= '0;
            rv_q      <= '0;
            resp_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |req_valid) begin
                ptr    <= gidx == IW'(N_REQ - 1) ? '0 : gidx + 1'b1;
                g      <= gidx;
                p1_q   <= req_p1[gidx*P_W +: P_W];
                p2_q   <= req_p2[gidx*P_W +: P_W];
                pdet_q <= req_pdet[gidx*5 +: 5];
            end
            if (state == RND && rnd_valid) begin
                rv_q[cnt*8 +: 8] <= rnd_data;
                cnt <= cnt == CW'(RB - 1) ? '0 : cnt + 1'b1;
            end
            if (state == WAIT && (mul_drdy_o || tmo))
                resp_data <= mul_drdy_o ? mul_out : '0;
            // leaving RESP means entering IDLE: drop the used randomness
            if (state == RESP)
                rv_q <= '0;
        end
    end

`ifdef CLM_MUL_TMO_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;

    assign tmo = state == WAIT && tcnt == TW'(TMO_CYC - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
            if (state == WAIT)
                err_q <= tmo && !mul_drdy_o;
        end
    end

    assign resp_err = state == RESP && err_q;
`else
    assign tmo = 1'b0;
    assign resp_err = 1'b0;
`endif

    // req_ready is combinational from req_valid, so it must be masked while reset is held
    assign req_ready       = (rst && state == IDLE) ? gnt : '0;
    assign resp_valid      = state == RESP ? N_REQ'(1) << g : '0;
    assign rnd_ready       = state == RND;
    assign mul_drdy_i      = state == ISSUE;
    assign mul_p1          = p1_q;
    assign mul_p2          = p2_q;
    assign mul_p_det       = pdet_q;
    assign mul_random_vect = rv_q;
endmodule

// File: tb/tb_clm_mul_sched.sv
// tb_clm_mul_sched: directed bench with RNG source and 3-cycle stub multiplier (product = p1 ^ p2).
module tb_clm_mul_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_p1 = '0;
    logic [63:0] req_p2 = '0;
    logic [19:0] req_pdet = '0;
    logic [3:0]  resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        rnd_valid;
    logic [7:0]  rnd_data;
    logic        rnd_ready;
    logic        mul_drdy_i;
    logic [15:0] mul_p1, mul_p2;
    logic [79:0] mul_random_vect;
    logic [4:0]  mul_p_det;
    logic        mul_drdy_o;
    logic [15:0] mul_out;

    logic        rnd_en = 1'b1;
    logic        stub_on = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  rnd_byte = 8'd1;
    int          hs_cnt = 0, di_cnt = 0, resp_cnt = 0;
    logic        err_seen = 1'b0;
    logic [1:0]  sc = '0;
    logic [15:0] sp = '0;
    int          errs = 0, checks = 0;

    always #5 clk = ~clk;

    clm_mul_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_p1(req_p1), .req_p2(req_p2), .req_pdet(req_pdet),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
        .mul_drdy_i(mul_drdy_i), .mul_p1(mul_p1), .mul_p2(mul_p2),
        .mul_random_vect(mul_random_vect), .mul_p_det(mul_p_det),
        .mul_drdy_o(mul_drdy_o), .mul_out(mul_out)
    );

    assign rnd_valid  = rnd_en;
    assign rnd_data   = rnd_byte;
    assign mul_drdy_o = stub_on && sc == 2'd1;
    assign mul_out    = sp;

    always @(posedge clk) begin
        if (clr) begin
            rnd_byte <= 8'd1;
            hs_cnt   <= 0;
            di_cnt   <= 0;
            resp_cnt <= 0;
            err_seen <= 1'b0;
        end else begin
            if (rnd_valid && rnd_ready) begin
                rnd_byte <= rnd_byte + 8'd1;
                hs_cnt   <= hs_cnt + 1;
            end
            if (mul_drdy_i) di_cnt <= di_cnt + 1;
            if (resp_valid != 0) resp_cnt <= resp_cnt + 1;
            if (resp_err) err_seen <= 1'b1;
        end
    end

    // stub multiplier: product shows on the third WAIT cycle
    always @(posedge clk) begin
        if (mul_drdy_i) begin
            sc <= 2'd3;
            sp <= mul_p1 ^ mul_p2;
        end else if (sc != 0) begin
            sc <= sc - 2'd1;
        end
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        clear_counts();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic wait_grant(output logic [3:0] gv);
        gv = '0;
        for (int i = 0; i < 100 && gv == 0; i++) begin
            @(negedge clk);
            gv = req_ready;
        end
    endtask

    task automatic wait_issue(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = mul_drdy_i;
        end
    endtask

    task automatic wait_resp(output logic [3:0] v, output logic [15:0] d, output logic e);
        v = '0;
        for (int i = 0; i < 400 && v == 0; i++) begin
            @(negedge clk);
            v = resp_valid;
        end
        d = resp_data;
        e = resp_err;
    endtask

    logic [3:0]  gv, v;
    logic [15:0] d;
    logic        e, ok;
    logic [15:0] exp2 [5];
    int          n;

    initial begin
        exp2[0] = 16'h00FF; exp2[1] = 16'h11EE; exp2[2] = 16'h22DD;
        exp2[3] = 16'h33CC; exp2[4] = 16'h00FF;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_rnd_ready", rnd_ready, 0);
        check("rst_drdy_i", mul_drdy_i, 0);
        check("rst_rv", mul_random_vect, 0);
        check("rst_p1", mul_p1, 0);
        do_reset();

        // single request on req0
        req_p1[15:0] = 16'h8000;
        req_p2[15:0] = 16'h8000;
        req_pdet[4:0] = 5'd11;
        req_valid = 4'b0001;
        wait_grant(gv);
        check("t1_grant", gv, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        wait_issue(ok);
        check("t1_issue", ok, 1);
        check("t1_rv", mul_random_vect, 80'h0A090807060504030201);
        check("t1_p1", mul_p1, 16'h8000);
        check("t1_pdet", mul_p_det, 5'd11);
        wait_resp(v, d, e);
        check("t1_valid", v, 4'b0001);
        check("t1_data", d, 16'h0000);
        check("t1_err", e, 0);
        check("t1_hs", hs_cnt, 10);
        check("t1_drdy_pulses", di_cnt, 1);
        @(negedge clk);
        check("t1_rv_cleared", mul_random_vect, 0);
        check("t1_valid_drop", resp_valid, 0);

        // all four requesting continuously
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_p1[i*16 +: 16] = 16'h1111 * 16'(i);
            req_p2[i*16 +: 16] = 16'h00FF;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(gv);
            check($sformatf("t2_grant%0d", k), gv, 4'b0001 << (k % 4));
            wait_resp(v, d, e);
            check($sformatf("t2_valid%0d", k), v, 4'b0001 << (k % 4));
            check($sformatf("t2_data%0d", k), d, exp2[k]);
        end
        req_valid = '0;

        // RNG stall after byte 4
        do_reset();
        req_p1[47:32] = 16'h1234;
        req_p2[47:32] = 16'h00FF;
        req_valid = 4'b0100;
        wait_grant(gv);
        check("t3_grant", gv, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 50 && hs_cnt != 4; i++) @(negedge clk);
        #1 rnd_en = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_stall_ready", rnd_ready, 1);
        check("t3_stall_hs", hs_cnt, 4);
        check("t3_stall_no_issue", di_cnt, 0);
        rnd_en = 1'b1;
        wait_resp(v, d, e);
        check("t3_valid", v, 4'b0100);
        check("t3_data", d, 16'h12CB);
        check("t3_hs", hs_cnt, 10);
        check("t3_drdy_pulses", di_cnt, 1);
        @(negedge clk);
        check("t3_data_hold", resp_data, 16'h12CB);

        // reset during WAIT
        do_reset();
        stub_on = 1'b0;
        req_valid = 4'b0001;
        wait_grant(gv);
        @(posedge clk); #1;
        req_valid = '0;
        wait_issue(ok);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t4_rst_rnd_ready", rnd_ready, 0);
        check("t4_rst_drdy_i", mul_drdy_i, 0);
        check("t4_rst_p1", mul_p1, 0);
        check("t4_rst_rv", mul_random_vect, 0);
        check("t4_rst_resp_data", resp_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        stub_on = 1'b1;
        req_p1[31:16] = 16'hA5A5;
        req_p2[31:16] = 16'h0F0F;
        req_valid = 4'b0010;
        wait_grant(gv);
        check("t4_grant", gv, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(v, d, e);
        check("t4_valid", v, 4'b0010);
        check("t4_data", d, 16'hAAAA);
        @(negedge clk);
        check("t4_resp_count", resp_cnt, 1);

        // multiplier never answers
        clear_counts();
        stub_on = 1'b0;
        req_valid = 4'b0001;
        wait_grant(gv);
        check("t5_grant", gv, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        wait_issue(ok);
        check("t5_issue", ok, 1);
        v = '0;
        n = 0;
        for (int i = 0; i < 500 && v == 0; i++) begin
            @(negedge clk);
            n++;
            v = resp_valid;
            d = resp_data;
            e = resp_err;
        end
`ifdef CLM_MUL_TMO_EN
        check("t5_tmo_cycles", n, 65);
        check("t5_tmo_valid", v, 4'b0001);
        check("t5_tmo_data", d, 16'h0000);
        check("t5_tmo_err", e, 1);
`else
        check("t5_no_resp", v, 0);
        check("t5_no_err", err_seen, 0);
        check("t5_resp_count", resp_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
